compressor_line_sequencer: RTL

//  Sequences one 128-bit cache line at a time through the 3-stage compressor pipeline.

---
 rtl/compressor_line_sequencer_if.sv | 46 ++++
 rtl/compressor_line_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/compressor_line_sequencer_if.sv
// Bundles the request, compressor and response channels of the line
// sequencer. The master side is the sequencer itself. The slave side is
// the surrounding logic: the requester, the compressor pipeline and the
// response consumer.
interface compressor_line_sequencer_if #(
   parameter int CACHE_LINE = 128,
   parameter int WIDTH      = 64,
   parameter int CNT_W      = 16
);
   // request channel
   logic                  i_req_valid;
   logic                  o_req_ready;
   logic [CACHE_LINE-1:0] i_req_line;
   // compressor channel
   logic                  o_comp_en;
   logic [WIDTH-1:0]      o_word;
   logic                  i_finish_final;
   logic                  i_compressed_flag;
   logic [CACHE_LINE-1:0] i_mux_array2;
   // response channel
   logic                  o_resp_valid;
   logic                  i_resp_ready;
   logic [CACHE_LINE-1:0] o_resp_line;
   logic                  o_resp_compressed;
   logic                  o_resp_timeout;
   // status
   logic                  o_busy;
   logic [CNT_W-1:0]      o_line_count;
   logic [CNT_W-1:0]      o_comp_count;

   modport master (
      input  i_req_valid, i_req_line, i_finish_final, i_compressed_flag,
             i_mux_array2, i_resp_ready,
      output o_req_ready, o_comp_en, o_word, o_resp_valid, o_resp_line,
             o_resp_compressed, o_resp_timeout, o_busy, o_line_count,
             o_comp_count
   );

   modport slave (
      output i_req_valid, i_req_line, i_finish_final, i_compressed_flag,
             i_mux_array2, i_resp_ready,
      input  o_req_ready, o_comp_en, o_word, o_resp_valid, o_resp_line,
             o_resp_compressed, o_resp_timeout, o_busy, o_line_count,
             o_comp_count
   );
endinterface

// File: rtl/compressor_line_sequencer.sv
// Feeds one cache line at a time through the 3-stage compressor.
// The line is sent as two words, low half first. Enable stays high while
// the pipeline drains. The packed result is captured on i_finish_final. If
// the finish does not arrive within TIMEOUT flush cycles, the original line
// is returned uncompressed. CACHE_LINE must equal 2*WIDTH.
module compressor_line_sequencer #(
   parameter int CACHE_LINE = 128,
   parameter int WIDTH      = 64,
   parameter int TIMEOUT    = 15,
   parameter int CNT_W      = 16
) (
   input logic                          i_clk,
   input logic                          i_reset,
   compressor_line_sequencer_if.master  bus
);

   localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND0,
      S_SEND1,
      S_FLUSH,
      S_RESP
   } state_t;

   state_t                state_q, state_nxt;
   logic [CACHE_LINE-1:0] line_q;
   logic [CACHE_LINE-1:0] result_q;
   logic                  compressed_q;
   logic                  timeout_q;
   logic [WAIT_W-1:0]     wait_q;
   logic [CNT_W-1:0]      line_cnt_q;
   logic [CNT_W-1:0]      comp_cnt_q;

   logic req_fire;
   logic resp_fire;
   logic finish_hit;
   logic timeout_hit;

   // finish takes priority over a timeout in the same flush cycle
   assign req_fire    = (state_q == S_IDLE) && bus.i_req_valid;
   assign resp_fire   = (state_q == S_RESP) && bus.i_resp_ready;
   assign finish_hit  = (state_q == S_FLUSH) && bus.i_finish_final;
   assign timeout_hit = (state_q == S_FLUSH) && !bus.i_finish_final
                        && (wait_q == WAIT_LAST);

   // state register
   // NOTE: sequential state uses non-blocking assignments only, so that
   // every flop samples the values from before the clock edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) state_q <= S_IDLE;
      else         state_q <= state_nxt;
   end

   // next-state logic
   // NOTE: a default is assigned before the case statement, so the
   // synthesis tool cannot infer a latch on a path that is not covered.
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         S_IDLE:  if (req_fire) state_nxt = S_SEND0;
         S_SEND0: state_nxt = S_SEND1;
         S_SEND1: state_nxt = S_FLUSH;
         S_FLUSH: if (finish_hit || timeout_hit) state_nxt = S_RESP;
         S_RESP:  if (resp_fire) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // line capture, flush wait counter, result capture and completion counters
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         line_q       <= '0;
         result_q     <= '0;
         compressed_q <= 1'b0;
         timeout_q    <= 1'b0;
         wait_q       <= '0;
         line_cnt_q   <= '0;
         comp_cnt_q   <= '0;
      end else begin
         if (req_fire) line_q <= bus.i_req_line;

         if (state_q == S_SEND1)      wait_q <= '0;
         else if (state_q == S_FLUSH) wait_q <= wait_q + 1'b1;

         if (finish_hit) begin
            result_q     <= bus.i_mux_array2;
            compressed_q <= bus.i_compressed_flag;
            timeout_q    <= 1'b0;
         end else if (timeout_hit) begin
            result_q     <= line_q;
            compressed_q <= 1'b0;
            timeout_q    <= 1'b1;
         end

         if (resp_fire) begin
            line_cnt_q <= line_cnt_q + 1'b1;
            if (compressed_q) comp_cnt_q <= comp_cnt_q + 1'b1;
         end
      end
   end

   // handshake and compressor outputs, decoded from the registered state
   always_comb begin
      bus.o_req_ready  = 1'b0;
      bus.o_comp_en    = 1'b0;
      bus.o_word       = '0;
      bus.o_resp_valid = 1'b0;
      unique case (state_q)
         S_IDLE:  bus.o_req_ready = 1'b1;
         S_SEND0: begin
            bus.o_comp_en = 1'b1;
            bus.o_word    = line_q[WIDTH-1:0];
         end
         S_SEND1: begin
            bus.o_comp_en = 1'b1;
            bus.o_word    = line_q[CACHE_LINE-1:WIDTH];
         end
         S_FLUSH: bus.o_comp_en    = 1'b1;
         S_RESP:  bus.o_resp_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.o_busy            = (state_q != S_IDLE);
   assign bus.o_resp_line       = result_q;
   assign bus.o_resp_compressed = compressed_q;
   assign bus.o_resp_timeout    = timeout_q;
   assign bus.o_line_count      = line_cnt_q;
   assign bus.o_comp_count      = comp_cnt_q;

endmodule
